id_exe_stage_reg: RTL and testbench
===================================

// Module: id_exe_stage_reg
// PURPOSE
//  ID->EXE pipeline register. Captures decoded control from the ID-stage controller
//  and operands from the register file and sign-extender, then presents them to the
//  EXE stage. It inserts bubbles on load-use hazards and squashes on taken branches.
//  It holds its contents while the memory stage freezes the pipe.
//  It also selects val2 as immediate or register, so EXE needs no mux.
// PARAMETERS
//  DATA_W  32  width of PC, operand and immediate paths
//  REG_W    5  register-index width (dest, src1, src2)
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       async reset, active-low
//  freeze           in   1       memory-stage stall; hold all state
//  flush            in   1       taken branch; squash the ID instruction
//  hazard_detected  in   1       load-use hazard; insert bubble
//  pc_in            in   DATA_W  PC+4 of the ID instruction
//  exe_cmd_in       in   4       ALU command from controller
//  wb_en_in         in   1       writeback enable
//  mem_r_en_in      in   1       load
//  mem_w_en_in      in   1       store
//  is_imm_in        in   1       val2 source: 1=imm_in, 0=reg2_in
//  dest_in          in   REG_W   destination register
//  src1_in          in   REG_W   rs index (forwarding)
//  src2_in          in   REG_W   rt index (forwarding)
//  reg1_in          in   DATA_W  rs value
//  reg2_in          in   DATA_W  rt value
//  imm_in           in   DATA_W  sign-extended immediate
//  valid_out        out  1       EXE holds a real instruction
//  pc_out, exe_cmd_out, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out
//                   out  as in   registered copies of the inputs
//  val1_out         out  DATA_W  registered reg1_in
//  val2_out         out  DATA_W  registered (is_imm_in ? imm_in : reg2_in)
//  st_val_out       out  DATA_W  registered reg2_in (store data)
//  src1_out         out  REG_W   registered src1_in (see CONFIGURATION)
//  src2_out         out  REG_W   registered src2_in (see CONFIGURATION)
//  bubble_cnt       out  16      saturating count of bubbles inserted
// BEHAVIOUR
//  - Reset (rst=0, async): every output and counter = 0, valid_out=0.
//  - Latency: 1 cycle. Each posedge clk applies exactly one action, in this priority:
//    1 freeze=1: hold all registers, including bubble_cnt. A pending flush or hazard
//      is ignored this cycle; the sources of both are frozen too and will reassert.
//    2 flush=1: load a bubble. bubble_cnt += 1.
//    3 hazard_detected=1: load a bubble. bubble_cnt += 1.
//    4 otherwise: load all inputs and set valid_out=1.
//  - Bubble: valid_out, wb_en, mem_r_en, mem_w_en and exe_cmd = 0.
//    All data fields, dest and src fields = 0.
//  - An instruction enters EXE only through action 4. An instruction with
//    wb_en=mem_w_en=0 and valid=1 (e.g. a branch) passes through unchanged.
//  - val2 mux is evaluated on the input side; the output is registered, not combinational.
//  - bubble_cnt saturates at 16'hFFFF and never wraps. It is reset only by rst.
//  - rst asserted mid-operation clears the register at once; the first load happens
//    on the first clk edge after rst deasserts.
// CONFIGURATION
//  - FORWARDING_EN defined: src1_out and src2_out are registered under the same
//    priority rules as the other fields.
//  - FORWARDING_EN undefined: src1_out and src2_out are tied to 0 and no flops are
//    built. The EXE forwarding unit must then be disabled.
// TESTING
//  1 rst=0 then release; no stall -> next edge shows reg1_in=32'h5,
//    exe_cmd_in=4'h1, wb_en=1 on the outputs; valid_out=1.
//  2 is_imm_in=1, imm_in=32'hFFFF_FFFC, reg2_in=32'h7 -> val2_out=32'hFFFF_FFFC,
//    st_val_out=32'h7. With is_imm_in=0 -> val2_out=32'h7.
//  3 hazard_detected=1 for 1 cycle after a load -> bubble: valid=0, wb/mem=0,
//    bubble_cnt 0->1. Next cycle loads the held instruction normally.
//  4 freeze=1 and flush=1 together for 3 cycles -> outputs unchanged, bubble_cnt
//    unchanged. Drop freeze -> one bubble, bubble_cnt +1.
//  5 Force bubble_cnt to 16'hFFFE, then 3 flushes -> count sticks at 16'hFFFF.
//  6 Drop rst mid-stream with valid_out=1 -> all outputs 0 immediately, before any
//    clk edge. With FORWARDING_EN: src1_in=5'd3 -> src1_out=3; without it, src1_out stays 0.

Source files
------------

// File: rtl/id_exe_stage_reg_if.sv
// id_exe_stage_reg_if: ID->EXE pipeline register bus (ID-side inputs, stall controls, EXE-side outputs)
interface id_exe_stage_reg_if #(parameter int DATA_W = 32, parameter int REG_W = 5);
  logic              freeze;
  logic              flush;
  logic              hazard_detected;
  logic [DATA_W-1:0] pc_in;
  logic [3:0]        exe_cmd_in;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic              is_imm_in;
  logic [REG_W-1:0]  dest_in;
  logic [REG_W-1:0]  src1_in;
  logic [REG_W-1:0]  src2_in;
  logic [DATA_W-1:0] reg1_in;
  logic [DATA_W-1:0] reg2_in;
  logic [DATA_W-1:0] imm_in;
  logic              valid_out;
  logic [DATA_W-1:0] pc_out;
  logic [3:0]        exe_cmd_out;
  logic              wb_en_out;
  logic              mem_r_en_out;
  logic              mem_w_en_out;
  logic [REG_W-1:0]  dest_out;
  logic [DATA_W-1:0] val1_out;
  logic [DATA_W-1:0] val2_out;
  logic [DATA_W-1:0] st_val_out;
  logic [REG_W-1:0]  src1_out;
  logic [REG_W-1:0]  src2_out;
  logic [15:0]       bubble_cnt;
  modport master (
    output freeze, flush, hazard_detected, pc_in, exe_cmd_in, wb_en_in, mem_r_en_in,
           mem_w_en_in, is_imm_in, dest_in, src1_in, src2_in, reg1_in, reg2_in, imm_in,
    input  valid_out, pc_out, exe_cmd_out, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out,
           val1_out, val2_out, st_val_out, src1_out, src2_out, bubble_cnt
  );
  modport slave (
    input  freeze, flush, hazard_detected, pc_in, exe_cmd_in, wb_en_in, mem_r_en_in,
           mem_w_en_in, is_imm_in, dest_in, src1_in, src2_in, reg1_in, reg2_in, imm_in,
    output valid_out, pc_out, exe_cmd_out, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out,
           val1_out, val2_out, st_val_out, src1_out, src2_out, bubble_cnt
  );
endinterface

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID->EXE pipeline register with bubble insertion, freeze hold and bubble counter
// Define FORWARDING_EN to register src1/src2 for the EXE forwarding unit; otherwise they are tied to 0.
module id_exe_stage_reg (
  input logic clk,
  input logic rst,
  id_exe_stage_reg_if.slave bus
);
  logic bubble;
  assign bubble = bus.flush | bus.hazard_detected;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.valid_out    <= 1'b0;
      bus.pc_out       <= '0;
      bus.exe_cmd_out  <= '0;
      bus.wb_en_out    <= 1'b0;
      bus.mem_r_en_out <= 1'b0;
      bus.mem_w_en_out <= 1'b0;
      bus.dest_out     <= '0;
      bus.val1_out     <= '0;
      bus.val2_out     <= '0;
      bus.st_val_out   <= '0;
      bus.bubble_cnt   <= '0;
    end else if (!bus.freeze) begin
      bus.valid_out    <= !bubble;
      bus.pc_out       <= bubble ? '0 : bus.pc_in;
      bus.exe_cmd_out  <= bubble ? '0 : bus.exe_cmd_in;
      bus.wb_en_out    <= !bubble && bus.wb_en_in;
      bus.mem_r_en_out <= !bubble && bus.mem_r_en_in;
      bus.mem_w_en_out <= !bubble && bus.mem_w_en_in;
      bus.dest_out     <= bubble ? '0 : bus.dest_in;
      bus.val1_out     <= bubble ? '0 : bus.reg1_in;
      bus.val2_out     <= bubble ? '0 : (bus.is_imm_in ? bus.imm_in : bus.reg2_in);
      bus.st_val_out   <= bubble ? '0 : bus.reg2_in;
      if (bubble && bus.bubble_cnt != 16'hFFFF) bus.bubble_cnt <= bus.bubble_cnt + 16'd1;
    end
`ifdef FORWARDING_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.src1_out <= '0;
      bus.src2_out <= '0;
    end else if (!bus.freeze) begin
      bus.src1_out <= bubble ? '0 : bus.src1_in;
      bus.src2_out <= bubble ? '0 : bus.src2_in;
    end
`else
  assign bus.src1_out = '0;
  assign bus.src2_out = '0;
`endif
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: directed self-checking bench for id_exe_stage_reg
module tb_id_exe_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  id_exe_stage_reg_if bus ();
  id_exe_stage_reg dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
`ifdef FORWARDING_EN
  localparam logic [4:0] SRC1_EXP = 5'd3;
`else
  localparam logic [4:0] SRC1_EXP = 5'd0;
`endif
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.freeze = 0; bus.flush = 0; bus.hazard_detected = 0;
    bus.pc_in = 32'h100; bus.exe_cmd_in = 4'h1; bus.wb_en_in = 1;
    bus.mem_r_en_in = 0; bus.mem_w_en_in = 0; bus.is_imm_in = 1;
    bus.dest_in = 5'd7; bus.src1_in = 5'd3; bus.src2_in = 5'd4;
    bus.reg1_in = 32'h5; bus.reg2_in = 32'h7; bus.imm_in = 32'hFFFF_FFFC;
    step();
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_val1", bus.val1_out, 0);
    chk("rst_cnt", bus.bubble_cnt, 0);
    rst = 1;
    step();
    chk("ld_val1", bus.val1_out, 32'h5);
    chk("ld_cmd", bus.exe_cmd_out, 4'h1);
    chk("ld_wb", bus.wb_en_out, 1);
    chk("ld_valid", bus.valid_out, 1);
    chk("ld_pc", bus.pc_out, 32'h100);
    chk("ld_dest", bus.dest_out, 5'd7);
    chk("imm_val2", bus.val2_out, 32'hFFFF_FFFC);
    chk("imm_st", bus.st_val_out, 32'h7);
    chk("ld_src1", bus.src1_out, SRC1_EXP);
    bus.is_imm_in = 0;
    step();
    chk("reg_val2", bus.val2_out, 32'h7);
    bus.mem_r_en_in = 1; bus.reg1_in = 32'h20;
    step();
    chk("load_mr", bus.mem_r_en_out, 1);
    bus.mem_r_en_in = 0; bus.reg1_in = 32'h33; bus.hazard_detected = 1;
    step();
    chk("hz_valid", bus.valid_out, 0);
    chk("hz_wb", bus.wb_en_out, 0);
    chk("hz_mr", bus.mem_r_en_out, 0);
    chk("hz_val1", bus.val1_out, 0);
    chk("hz_dest", bus.dest_out, 0);
    chk("hz_src1", bus.src1_out, 0);
    chk("hz_cnt", bus.bubble_cnt, 1);
    bus.hazard_detected = 0;
    step();
    chk("hz_next_valid", bus.valid_out, 1);
    chk("hz_next_val1", bus.val1_out, 32'h33);
    chk("hz_next_cnt", bus.bubble_cnt, 1);
    bus.freeze = 1; bus.flush = 1; bus.reg1_in = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_val1", bus.val1_out, 32'h33);
      chk("frz_valid", bus.valid_out, 1);
      chk("frz_cnt", bus.bubble_cnt, 1);
    end
    bus.freeze = 0;
    step();
    chk("unfrz_valid", bus.valid_out, 0);
    chk("unfrz_cnt", bus.bubble_cnt, 2);
    force bus.bubble_cnt = 16'hFFFE;
    #1;
    release bus.bubble_cnt;
    step();
    chk("sat_1", bus.bubble_cnt, 16'hFFFF);
    step();
    chk("sat_2", bus.bubble_cnt, 16'hFFFF);
    step();
    chk("sat_3", bus.bubble_cnt, 16'hFFFF);
    bus.flush = 0;
    step();
    chk("pre_rst_valid", bus.valid_out, 1);
    #2 rst = 0;
    #1;
    chk("arst_valid", bus.valid_out, 0);
    chk("arst_val1", bus.val1_out, 0);
    chk("arst_wb", bus.wb_en_out, 0);
    chk("arst_cnt", bus.bubble_cnt, 0);
    step();
    rst = 1;
    step();
    chk("post_valid", bus.valid_out, 1);
    chk("post_src1", bus.src1_out, SRC1_EXP);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
